// File: rtl/riscv_core_mul_iter.sv
// Sequential radix-16 modified-Booth multiplier for the RV64M multiply path.
// One Booth digit per clock, LSB first; the full 2*XLEN product is latched on entry to DONE.
module riscv_core_mul_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_mul_start,
    input  logic                i_mul_flush,
    input  logic [1:0]          i_mul_control,
    input  logic                i_mul_isword,
    input  logic [XLEN-1:0]     i_mul_rs1,
    input  logic [XLEN-1:0]     i_mul_rs2,
    output logic                o_mul_busy,
    output logic                o_mul_valid,
    output logic [2*XLEN-1:0]   o_mul_product,
    output logic [1:0]          o_mul_control,
    output logic                o_mul_isword
);

    localparam int unsigned ITER   = (XLEN + 4) / 4;
    localparam int unsigned ITER_W = (XLEN / 2 + 4) / 4;
    localparam int unsigned HW     = XLEN / 2;
    localparam int unsigned EW     = XLEN + 4;          // extended operand width
    localparam int unsigned XW     = XLEN + 8;          // partial-product / accumulator head width
    localparam int unsigned LW     = 4 * ITER;          // bits shifted out over a full op
    localparam int unsigned PW     = XW + LW;
    localparam int unsigned CW     = $clog2(ITER + 1);
    localparam int unsigned SH     = 4 * (ITER - ITER_W); // word result sits this far up after ITER_W digits

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                busy_q, busy_d, valid_q, valid_d;
    logic [EW-1:0]       a_q, a_d, y_q, y_d;
    logic                yprev_q;
    logic [XW-1:0]       a3_q, a5_q, a7_q;
    logic [PW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          ctrl_q;
    logic                isw_q;
    logic [2*XLEN-1:0]   product_q;
    logic [1:0]          out_ctrl_q;
    logic                out_isw_q;

    logic                accept_c, rs1_sgn_c, rs2_sgn_c;
    logic [XLEN-1:0]     src1_c, src2_c;
    logic [CW-1:0]       n_iter_c;
    logic [XW-1:0]       aw_c, mult_c, pp_c, sum_c;
    logic [4:0]          dig_c, dig_neg_c;
    logic [3:0]          mag_c;
    logic                neg_c;
    logic [PW-1:0]       acc_sum_c;
    logic [2*XLEN-1:0]   result_c;

    assign accept_c = (state_q == S_IDLE) && i_mul_start && !i_mul_flush;
    assign n_iter_c = isw_q ? CW'(ITER_W) : CW'(ITER);

    // Operand extension: word ops sign-extend low halves and ignore control
    always_comb begin
        rs1_sgn_c = i_mul_isword || (i_mul_control != 2'b11);
        rs2_sgn_c = i_mul_isword || !i_mul_control[1];
        src1_c    = i_mul_isword ? {{HW{i_mul_rs1[HW-1]}}, i_mul_rs1[HW-1:0]} : i_mul_rs1;
        src2_c    = i_mul_isword ? {{HW{i_mul_rs2[HW-1]}}, i_mul_rs2[HW-1:0]} : i_mul_rs2;
        a_d       = {{4{rs1_sgn_c & src1_c[XLEN-1]}}, src1_c};
        y_d       = {{4{rs2_sgn_c & src2_c[XLEN-1]}}, src2_c};
    end

    // Booth digit decode, multiple select and accumulate-with-shift
    always_comb begin
        aw_c      = {{4{a_q[EW-1]}}, a_q};
        dig_c     = {y_q[3], y_q[3:0]} + {4'b0, yprev_q};
        dig_neg_c = ~dig_c + 5'd1;
        neg_c     = dig_c[4];
        mag_c     = neg_c ? dig_neg_c[3:0] : dig_c[3:0];
        case (mag_c)
            4'd1:    mult_c = aw_c;
            4'd2:    mult_c = aw_c << 1;
            4'd3:    mult_c = a3_q;
            4'd4:    mult_c = aw_c << 2;
            4'd5:    mult_c = a5_q;
            4'd6:    mult_c = a3_q << 1;
            4'd7:    mult_c = a7_q;
            4'd8:    mult_c = aw_c << 3;
            default: mult_c = '0;
        endcase
        pp_c      = neg_c ? ~mult_c : mult_c;
        sum_c     = acc_q[PW-1 -: XW] + pp_c + XW'(neg_c);
        acc_sum_c = {sum_c, acc_q[LW-1:0]};
        acc_d     = PW'($signed(acc_sum_c) >>> 4);
        result_c  = isw_q ? {{XLEN{acc_d[SH+XLEN-1]}}, acc_d[SH +: XLEN]}
                          : acc_d[2*XLEN-1:0];
    end

    // State register and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; flush wins over start and aborts any op in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c) state_d = S_CALC;
            S_CALC: begin
                if (i_mul_flush)            state_d = S_IDLE;
                else if (cnt_q == n_iter_c) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/valid come straight from flops
    always_comb begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // Datapath: latch at accept, build odd multiples on the first CALC cycle, then iterate
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q        <= '0;
            y_q        <= '0;
            yprev_q    <= 1'b0;
            a3_q       <= '0;
            a5_q       <= '0;
            a7_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ctrl_q     <= 2'b00;
            isw_q      <= 1'b0;
            product_q  <= '0;
            out_ctrl_q <= 2'b00;
            out_isw_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q    <= a_d;
                y_q    <= y_d;
                ctrl_q <= i_mul_control;
                isw_q  <= i_mul_isword;
                cnt_q  <= '0;
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == '0) begin
                    a3_q    <= aw_c + (aw_c << 1);
                    a5_q    <= aw_c + (aw_c << 2);
                    a7_q    <= (aw_c << 3) - aw_c;
                    acc_q   <= '0;
                    yprev_q <= 1'b0;
                end else begin
                    acc_q   <= acc_d;
                    y_q     <= {4'b0, y_q[EW-1:4]};
                    yprev_q <= y_q[3];
                end
            end
            if (state_q == S_CALC && state_d == S_DONE) begin
                product_q  <= result_c;
                out_ctrl_q <= ctrl_q;
                out_isw_q  <= isw_q;
            end
        end
    end

    assign o_mul_busy    = busy_q;
    assign o_mul_valid   = valid_q;
    assign o_mul_product = product_q;
    assign o_mul_control = out_ctrl_q;
    assign o_mul_isword  = out_isw_q;

endmodule

// File: tb/tb_riscv_core_mul_iter.sv
// Directed bench for riscv_core_mul_iter: vector table plus busy/flush/reset sequences.
module tb_riscv_core_mul_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, flush, isword;
    logic [1:0]   control;
    logic [63:0]  rs1, rs2;
    logic         busy, valid, o_isword;
    logic [127:0] product;
    logic [1:0]   o_control;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_core_mul_iter #(.XLEN(64)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mul_start   (start),
        .i_mul_flush   (flush),
        .i_mul_control (control),
        .i_mul_isword  (isword),
        .i_mul_rs1     (rs1),
        .i_mul_rs2     (rs2),
        .o_mul_busy    (busy),
        .o_mul_valid   (valid),
        .o_mul_product (product),
        .o_mul_control (o_control),
        .o_mul_isword  (o_isword)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   ctrl;
        logic         isw;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] prod;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] c, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        start = 1'b1; control = c; isword = w; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0;
        check({name, " busy after accept"}, 128'(busy), 128'd1);
        lat = 0;
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 128'(lat), 128'(exp_lat));
        check({name, " product"}, product, exp);
        check({name, " control"}, 128'(o_control), 128'(c));
        check({name, " isword"}, 128'(o_isword), 128'(w));
        @(negedge clk);
        check({name, " valid one cycle"}, 128'(valid), 128'd0);
        check({name, " busy drop"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int vcount, vat;
        logic busy19, busy20;

        vecs[0] = '{2'b11, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                    128'hFFFFFFFFFFFFFFFE_0000000000000001, 18};
        vecs[1] = '{2'b00, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd5,
                    128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFB, 18};
        vecs[2] = '{2'b01, 1'b0, 64'h8000000000000000, 64'h8000000000000000,
                    128'h4000000000000000_0000000000000000, 18};
        vecs[3] = '{2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                    128'hFFFFFFFFFFFFFFFF_0000000000000001, 18};
        vecs[4] = '{2'b00, 1'b1, 64'h1234567880000000, 64'h0000000000000002,
                    128'hFFFFFFFFFFFFFFFF_FFFFFFFF00000000, 10};
        vecs[5] = '{2'b01, 1'b0, 64'h8000000000000000, 64'd1,
                    128'hFFFFFFFFFFFFFFFF_8000000000000000, 18};
        vecs[6] = '{2'b11, 1'b0, 64'h8000000000000000, 64'd2,
                    128'h0000000000000001_0000000000000000, 18};
        vecs[7] = '{2'b10, 1'b0, 64'd2, 64'hFFFFFFFFFFFFFFFF,
                    128'h0000000000000001_FFFFFFFFFFFFFFFE, 18};
        vecs[8] = '{2'b11, 1'b1, 64'hABCDEF01FFFFFFFF, 64'h0000000000000003,
                    128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFD, 10};
        vecs[9] = '{2'b00, 1'b1, 64'h000000007FFFFFFF, 64'hFFFFFFFF7FFFFFFF,
                    128'h0000000000000000_3FFFFFFF00000001, 10};

        rst = 1'b1; start = 1'b0; flush = 1'b0; control = 2'b00; isword = 1'b0;
        rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 128'(busy), 128'd0);
        check("reset valid", 128'(valid), 128'd0);
        check("reset product", product, 128'd0);
        check("reset control", 128'(o_control), 128'd0);
        check("reset isword", 128'(o_isword), 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].isw, vecs[i].a, vecs[i].b,
                   vecs[i].prod, vecs[i].lat);

        // Starts while busy (mid-CALC, last CALC, DONE) are all ignored
        @(negedge clk);
        start = 1'b1; control = 2'b00; isword = 1'b0; rs1 = 64'd3; rs2 = 64'd7;
        vcount = 0; vat = -1; busy19 = 1'b1; busy20 = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (valid) begin vcount++; vat = c; end
            if (c == 19) busy19 = busy;
            if (c == 20) busy20 = busy;
            start = (c == 2 || c == 16 || c == 18);
            rs1 = 64'd9; rs2 = 64'd9;
        end
        start = 1'b0;
        check("busy-start valid count", 128'(vcount), 128'd1);
        check("busy-start valid cycle", 128'(vat), 128'd18);
        check("busy-start product", product, 128'd21);
        check("busy-start busy drop", 128'(busy19), 128'd0);
        check("busy-start no requeue", 128'(busy20), 128'd0);

        // Flush mid-CALC: back to idle, no valid, previous product kept
        @(negedge clk);
        start = 1'b1; control = 2'b11; isword = 1'b0; rs1 = 64'd100; rs2 = 64'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy drop", 128'(busy), 128'd0);
        vcount = 0;
        repeat (30) begin @(negedge clk); if (valid) vcount++; end
        check("flush no valid", 128'(vcount), 128'd0);
        check("flush product kept", product, 128'd21);
        check("flush control kept", 128'(o_control), 128'd0);

        // Start and flush together in IDLE: nothing accepted
        start = 1'b1; flush = 1'b1; rs1 = 64'd5; rs2 = 64'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("start+flush busy", 128'(busy), 128'd0);
        vcount = 0;
        repeat (25) begin @(negedge clk); if (valid) vcount++; end
        check("start+flush no valid", 128'(vcount), 128'd0);

        // Reset mid-CALC clears every output
        run_op("pre-reset word", 2'b11, 1'b1, 64'd6, 64'd7, 128'd42, 10);
        @(negedge clk);
        start = 1'b1; control = 2'b01; isword = 1'b0; rs1 = 64'd11; rs2 = 64'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", 128'(busy), 128'd0);
        check("midreset valid", 128'(valid), 128'd0);
        check("midreset product", product, 128'd0);
        check("midreset control", 128'(o_control), 128'd0);
        check("midreset isword", 128'(o_isword), 128'd0);
        vcount = 0;
        repeat (25) begin @(negedge clk); if (valid) vcount++; end
        check("midreset no valid", 128'(vcount), 128'd0);

        run_op("post-reset", 2'b00, 1'b0, 64'd6, 64'd7, 128'd42, 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
